// File: rtl/alu16_reg.sv
// Registered 16-bit ALU execute stage: one-cycle latency, valid-qualified.
// Result and NZCV flags hold when no operation is issued.
module alu16_reg #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] dataX,
    input  logic [WIDTH-1:0] dataY,
    output logic [WIDTH-1:0] ALUresult,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SLL = 3'd6,
        OP_SRA = 3'd7
    } op_e;

    logic [WIDTH-1:0]   r;
    logic               c;
    logic               v;
    logic [SHAMT_W-1:0] s;
    logic [WIDTH:0]     wide;

    assign s = dataY[SHAMT_W-1:0];

    // Shifts run on a 17-bit value so the extra bit catches the last bit out.
    always_comb begin
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        wide = '0;
        unique case (op_e'(operation))
            OP_ADD: begin
                wide = {1'b0, dataX} + {1'b0, dataY};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (dataX[WIDTH-1] == dataY[WIDTH-1]) &&
                       (r[WIDTH-1] != dataX[WIDTH-1]);
            end
            OP_SUB: begin
                wide = {1'b0, dataX} - {1'b0, dataY};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (dataX[WIDTH-1] != dataY[WIDTH-1]) &&
                       (r[WIDTH-1] != dataX[WIDTH-1]);
            end
            OP_AND: r = dataX & dataY;
            OP_OR:  r = dataX | dataY;
            OP_XOR: r = dataX ^ dataY;
            OP_NOT: r = ~dataX;
            OP_SLL: begin
                wide = {1'b0, dataX} << s;
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
            end
            OP_SRA: begin
                wide = $unsigned($signed({dataX, 1'b0}) >>> s);
                r    = wide[WIDTH:1];
                c    = wide[0];
            end
            default: begin
                r = '0;
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUresult <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ALUresult <= r;
                zero      <= (r == '0);
                negative  <= r[WIDTH-1];
                carry     <= c;
                overflow  <= v;
            end
        end
    end

endmodule

// File: tb/tb_alu16_reg.sv
// Scoreboard bench for alu16_reg: directed vectors queued at issue,
// checked by an independent monitor when out_valid is seen.
module tb_alu16_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  operation = '0;
    logic [15:0] dataX = '0;
    logic [15:0] dataY = '0;
    logic [15:0] ALUresult;
    logic        out_valid;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;

    alu16_reg dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .operation(operation),
        .dataX(dataX),
        .dataY(dataY),
        .ALUresult(ALUresult),
        .out_valid(out_valid),
        .zero(zero),
        .negative(negative),
        .carry(carry),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic [31:0] t;
        logic [15:0] id;
    } sb_t;

    sb_t  q[$];
    exp_t last_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nvec = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] r,
                         input logic c, input logic v);
        sb_t item;
        @(negedge clk);
        in_valid  = 1'b1;
        operation = op;
        dataX     = x;
        dataY     = y;
        item.e    = '{r: r, z: (r == 16'h0), n: r[15], c: c, v: v};
        item.t    = cyc + 1;
        item.id   = 16'(nvec);
        nvec++;
        last_e    = item.e;
        q.push_back(item);
    endtask

    // Monitor: every out_valid pulse must match the oldest queued vector.
    always @(posedge clk) begin
        sb_t  item;
        exp_t got;
        #1;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                item = q.pop_front();
                got  = '{r: ALUresult, z: zero, n: negative,
                         c: carry, v: overflow};
                check($sformatf("vec%0d_rznc v", item.id),
                      32'(got), 32'(item.e));
                check($sformatf("vec%0d_latency", item.id),
                      32'(cyc), item.t);
            end
        end
    end

    initial begin
        exp_t held;
        // Reset with live, nonzero inputs.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        operation = 3'd0;
        dataX     = 16'h7FFF;
        dataY     = 16'h0001;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({ALUresult, zero, negative, carry, overflow, out_valid}),
              32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Reset arriving after issue, before the capture edge.
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 3'd3;
        dataX     = 16'h1234;
        dataY     = 16'h4321;
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reset_discard",
              32'({ALUresult, zero, negative, carry, overflow, out_valid}),
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back directed vectors.
        issue(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        issue(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        issue(3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
        issue(3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        issue(3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0);
        issue(3'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0);
        issue(3'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0);
        issue(3'd5, 16'hF0F0, 16'h0FF0, 16'h0F0F, 1'b0, 1'b0);
        issue(3'd6, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0);
        issue(3'd7, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0);
        issue(3'd7, 16'h0003, 16'h0011, 16'h0001, 1'b1, 1'b0);
        issue(3'd6, 16'h1234, 16'hFFF0, 16'h1234, 1'b0, 1'b0);
        issue(3'd7, 16'h8765, 16'h0010, 16'h8765, 1'b0, 1'b0);
        issue(3'd6, 16'h0003, 16'h000F, 16'h8000, 1'b1, 1'b0);
        issue(3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
        issue(3'd1, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        // Idle cycles with changing inputs must not disturb the outputs.
        held = last_e;
        for (int i = 0; i < 3; i++) begin
            operation = 3'(i);
            dataX     = 16'($urandom);
            dataY     = 16'($urandom);
            @(negedge clk);
            check($sformatf("hold%0d", i),
                  32'({ALUresult, zero, negative, carry, overflow,
                       out_valid}),
                  32'({held, 1'b0}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
